// File: rtl/apb_bus_master_if.sv
// ---------------------------------------------------------------------------
// apb_bus_master_if
//
// APB-style peripheral bus between the CPU bridge (master) and a set of
// NUM_SLAVES peripherals (slave side). Each slave has its own select, ready,
// error and read-data lane. Slave i drives PRDATA[32*i +: 32].
//
// Signals:
//   PADDR    32          byte address, held for the whole transfer
//   PWDATA   32          write data
//   PWRITE   1           1 = write, 0 = read
//   PSTRB    4           write byte strobes (0 on reads)
//   PSEL     NUM_SLAVES  one-hot slave select
//   PENABLE  1           ACCESS-phase indicator
//   PRDATA   32*N        per-slave read data lanes
//   PREADY   NUM_SLAVES  per-slave ready
//   PSLVERR  NUM_SLAVES  per-slave error, meaningful with PREADY
// ---------------------------------------------------------------------------
interface apb_bus_master_if #(
    parameter int NUM_SLAVES = 4
) ();

    logic [31:0]             PADDR;
    logic [31:0]             PWDATA;
    logic                    PWRITE;
    logic [3:0]              PSTRB;
    logic [NUM_SLAVES-1:0]   PSEL;
    logic                    PENABLE;
    logic [32*NUM_SLAVES-1:0] PRDATA;
    logic [NUM_SLAVES-1:0]   PREADY;
    logic [NUM_SLAVES-1:0]   PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSTRB, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSTRB, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_bus_master.sv
// ---------------------------------------------------------------------------
// apb_bus_master
//
// Bridges the core's single-cycle data bus to the APB peripheral bus. One CPU
// access is captured in IDLE, presented to the decoded slave through SETUP
// and ACCESS phases, and completed back to the core with a one-cycle ready
// pulse. Unmapped addresses and slaves that never raise PREADY complete with
// err=1 instead of hanging the core.
//
// Address map: slave i occupies 0x1000_i000 - 0x1000_iFFF.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-low
//   transfer     CPU request, level, held until ready
//   busWe        1 = write, 0 = read
//   busAddr      byte address
//   busWData     write data
//   Byte_Enable  write byte strobes
//   busRData     read data, valid with ready (0 otherwise)
//   ready        one-cycle completion pulse
//   err          completion error flag, valid with ready
//   apb          APB master side (see apb_bus_master_if)
// ---------------------------------------------------------------------------
module apb_bus_master #(
    parameter int NUM_SLAVES     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    transfer,
    input  logic                    busWe,
    input  logic [31:0]             busAddr,
    input  logic [31:0]             busWData,
    input  logic [3:0]              Byte_Enable,
    output logic [31:0]             busRData,
    output logic                    ready,
    output logic                    err,
    apb_bus_master_if.master        apb
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_e;

    state_e             state_q,  state_d;
    logic [31:0]        paddr_q,  paddr_d;
    logic [31:0]        pwdata_q, pwdata_d;
    logic               pwrite_q, pwrite_d;
    logic [3:0]         pstrb_q,  pstrb_d;
    logic               mapped_q, mapped_d;
    logic [3:0]         idx_q,    idx_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;

    // Response lines of the currently addressed slave only; the others are
    // ignored entirely.
    logic               sel_pready;
    logic               sel_pslverr;
    logic [31:0]        sel_prdata;
    logic [NUM_SLAVES-1:0] sel_onehot;

    always_comb begin
        sel_pready  = 1'b0;
        sel_pslverr = 1'b0;
        sel_prdata  = '0;
        sel_onehot  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == 4'(i)) begin
                sel_pready    = apb.PREADY[i];
                sel_pslverr   = apb.PSLVERR[i];
                sel_prdata    = apb.PRDATA[32*i +: 32];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        pstrb_d  = pstrb_q;
        mapped_d = mapped_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        ready    = 1'b0;
        err      = 1'b0;
        busRData = '0;

        case (state_q)
            IDLE: begin
                if (transfer) begin
                    paddr_d  = busAddr;
                    pwdata_d = busWData;
                    pwrite_d = busWe;
                    pstrb_d  = busWe ? Byte_Enable : 4'h0;
                    mapped_d = (busAddr[31:16] == 16'h1000) &&
                               (32'(busAddr[15:12]) < NUM_SLAVES);
                    idx_d    = busAddr[15:12];
                    cnt_d    = '0;
                    state_d  = SETUP;
                end
            end

            SETUP: begin
                if (mapped_q) begin
                    state_d = ACCESS;
                end else begin
                    // Unmapped: fail fast without touching the bus.
                    ready   = 1'b1;
                    err     = 1'b1;
                    state_d = IDLE;
                end
            end

            ACCESS: begin
                // A slave answering in the last allowed cycle still wins over
                // the timeout.
                if (sel_pready) begin
                    ready    = 1'b1;
                    err      = sel_pslverr;
                    busRData = pwrite_q ? 32'h0 : sel_prdata;
                    state_d  = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    ready   = 1'b1;
                    err     = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop sees
    // the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            pstrb_q  <= '0;
            mapped_q <= 1'b0;
            idx_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            pstrb_q  <= pstrb_d;
            mapped_q <= mapped_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
        end
    end

    // APB outputs come from flops only, so the CPU inputs have no
    // combinational path onto the peripheral bus.
    assign apb.PADDR   = paddr_q;
    assign apb.PWDATA  = pwdata_q;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PSTRB   = pstrb_q;
    assign apb.PSEL    = (state_q != IDLE && mapped_q) ? sel_onehot : '0;
    assign apb.PENABLE = (state_q == ACCESS);

endmodule

// File: tb/tb_apb_bus_master.sv
// ---------------------------------------------------------------------------
// tb_apb_bus_master
//
// Drives CPU accesses into apb_bus_master, emulates the APB slaves, and
// compares every completion against a transaction-level expectation held in
// a scoreboard queue.
// ---------------------------------------------------------------------------
module tb_apb_bus_master;

    localparam int NS = 4;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        transfer;
    logic        busWe;
    logic [31:0] busAddr;
    logic [31:0] busWData;
    logic [3:0]  Byte_Enable;
    logic [31:0] busRData;
    logic        ready;
    logic        err;

    apb_bus_master_if #(.NUM_SLAVES(NS)) apb ();

    apb_bus_master #(
        .NUM_SLAVES     (NS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .transfer    (transfer),
        .busWe       (busWe),
        .busAddr     (busAddr),
        .busWData    (busWData),
        .Byte_Enable (Byte_Enable),
        .busRData    (busRData),
        .ready       (ready),
        .err         (err),
        .apb         (apb)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- expected-transaction model ----------------
    typedef struct {
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic          we;
        logic [3:0]    strb;
        logic [NS-1:0] psel;
        int            lat;
        logic          err;
        logic [31:0]   rdata;
        int            start;
    } exp_t;

    exp_t sb_q[$];

    // waits = number of ACCESS cycles the addressed slave holds PREADY low.
    function automatic exp_t model(input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic we, input logic [3:0] be, input int waits,
                                   input logic slverr, input logic [31:0] rdata,
                                   input int start);
        exp_t e;
        int   slot;
        e.addr  = addr;
        e.wdata = wdata;
        e.we    = we;
        e.strb  = we ? be : 4'h0;
        e.start = start;
        e.psel  = '0;
        slot    = int'(addr[15:12]);
        if (addr[31:16] != 16'h1000 || slot >= NS) begin
            e.lat   = 1;
            e.err   = 1'b1;
            e.rdata = 32'h0;
        end else begin
            e.psel[slot] = 1'b1;
            if (waits < TO) begin
                e.lat   = 2 + waits;
                e.err   = slverr;
                e.rdata = we ? 32'h0 : rdata;
            end else begin
                e.lat   = 1 + TO;
                e.err   = 1'b1;
                e.rdata = 32'h0;
            end
        end
        return e;
    endfunction

    // ---------------- slave emulation ----------------
    int          plan_waits = 0;
    logic        plan_err   = 1'b0;
    logic [31:0] plan_rdata = 32'h0;
    int          acc_cnt    = 0;

    // Non-selected lanes carry random noise that the bridge must ignore.
    always @(negedge clk) begin
        for (int i = 0; i < NS; i++) begin
            apb.PREADY[i]         = 1'($urandom);
            apb.PSLVERR[i]        = 1'($urandom);
            apb.PRDATA[32*i +: 32] = $urandom;
        end
        if (|apb.PSEL && apb.PENABLE) begin
            for (int i = 0; i < NS; i++) begin
                if (apb.PSEL[i]) begin
                    apb.PREADY[i]          = (acc_cnt == plan_waits);
                    apb.PSLVERR[i]         = plan_err;
                    apb.PRDATA[32*i +: 32] = plan_rdata;
                end
            end
            acc_cnt++;
        end else begin
            acc_cnt = 0;
        end
    end

    // ---------------- monitor ----------------
    int last_ready_cyc = -10;

    always begin
        @(negedge clk);
        #1;
        if (reset) begin
            if (cyc == last_ready_cyc + 1) begin
                check("idle_after_done_psel", 64'(apb.PSEL), 64'h0);
                check("idle_after_done_penable", 64'(apb.PENABLE), 64'h0);
            end
            if (sb_q.size() > 0 && cyc == sb_q[0].start + 1 && sb_q[0].psel != '0) begin
                check("setup_psel", 64'(apb.PSEL), 64'(sb_q[0].psel));
                check("setup_penable", 64'(apb.PENABLE), 64'h0);
            end
            if (ready) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL spurious_ready: got ready=1 expected no completion (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("latency", 64'(cyc - e.start), 64'(e.lat));
                    check("err", 64'(err), 64'(e.err));
                    check("rdata", 64'(busRData), 64'(e.rdata));
                    check("psel", 64'(apb.PSEL), 64'(e.psel));
                    check("penable", 64'(apb.PENABLE), 64'(e.psel != '0));
                    check("paddr", 64'(apb.PADDR), 64'(e.addr));
                    check("pwdata", 64'(apb.PWDATA), 64'(e.wdata));
                    check("pwrite", 64'(apb.PWRITE), 64'(e.we));
                    check("pstrb", 64'(apb.PSTRB), 64'(e.strb));
                end
                last_ready_cyc = cyc;
            end else begin
                check("quiet_when_not_ready", {31'h0, err, busRData}, 64'h0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_access(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                             input logic [3:0] be, input int waits, input logic slverr,
                             input logic [31:0] rdata);
        bit got;
        plan_waits  = waits;
        plan_err    = slverr;
        plan_rdata  = rdata;
        transfer    = 1'b1;
        busWe       = we;
        busAddr     = addr;
        busWData    = wdata;
        Byte_Enable = be;
        sb_q.push_back(model(addr, wdata, we, be, waits, slverr, rdata, cyc));
        got = 1'b0;
        for (int k = 0; k < TO + 8; k++) begin
            @(negedge clk);
            #2;
            if (ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            tests++;
            failed++;
            $display("FAIL no_completion: got no ready for addr %0h expected one within %0d cycles", addr, TO + 8);
            sb_q.delete();
        end
        @(posedge clk);
        #1;
        transfer = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_mid_access();
        plan_waits  = 10;
        transfer    = 1'b1;
        busWe       = 1'b1;
        busAddr     = 32'h1000_1008;
        busWData    = 32'hA5A5_5A5A;
        Byte_Enable = 4'hF;
        repeat (4) @(posedge clk);
        #1;
        reset    = 1'b0;
        transfer = 1'b0;
        @(posedge clk);
        #1;
        check("rst_psel", 64'(apb.PSEL), 64'h0);
        check("rst_penable", 64'(apb.PENABLE), 64'h0);
        check("rst_pwrite", 64'(apb.PWRITE), 64'h0);
        check("rst_pstrb", 64'(apb.PSTRB), 64'h0);
        check("rst_paddr", 64'(apb.PADDR), 64'h0);
        check("rst_pwdata", 64'(apb.PWDATA), 64'h0);
        check("rst_ready", {31'h0, ready, err, busRData}, 64'h0);
        reset = 1'b1;
        idle_cycles(3);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] addr;
        int          kind;
        int          waits;
        int          r;

        reset       = 1'b0;
        transfer    = 1'b0;
        busWe       = 1'b0;
        busAddr     = '0;
        busWData    = '0;
        Byte_Enable = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_psel", 64'(apb.PSEL), 64'h0);
        check("reset_penable", 64'(apb.PENABLE), 64'h0);
        check("reset_paddr", 64'(apb.PADDR), 64'h0);
        check("reset_outs", {31'h0, ready, err, busRData}, 64'h0);
        reset = 1'b1;
        idle_cycles(2);

        // Zero-wait write to slave 1.
        do_access(32'h1000_1004, 1'b1, 32'hDEAD_BEEF, 4'b0011, 0, 1'b0, 32'h0);
        idle_cycles(1);
        // Read from slave 2 with three wait states.
        do_access(32'h1000_2010, 1'b0, 32'h0, 4'hF, 3, 1'b0, 32'h1234_5678);
        // Unmapped reads, then a timeout.
        do_access(32'h2000_0000, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h1111_1111);
        do_access(32'h1000_5000, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h2222_2222);
        do_access(32'h1000_0040, 1'b0, 32'h0, 4'h0, 100, 1'b0, 32'h3333_3333);
        // Slave error, immediately followed by a clean read from slave 0.
        do_access(32'h1000_3000, 1'b1, 32'h0BAD_F00D, 4'hF, 1, 1'b1, 32'h0);
        do_access(32'h1000_0ABC, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'hCAFE_F00D);
        // Timeout boundary: answering in the last allowed cycle vs one later.
        do_access(32'h1000_2FFC, 1'b0, 32'h0, 4'h0, TO - 1, 1'b0, 32'h7777_0001);
        do_access(32'h1000_2FFC, 1'b0, 32'h0, 4'h0, TO, 1'b0, 32'h7777_0002);
        // Reset during a wait state, then a normal access.
        reset_mid_access();
        do_access(32'h1000_1100, 1'b0, 32'h0, 4'h0, 2, 1'b0, 32'h5555_AAAA);

        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 9);
            addr = $urandom;
            if (kind == 0) begin
                if (addr[31:16] == 16'h1000) addr[31] = 1'b1;
            end else if (kind == 1) begin
                addr[31:16] = 16'h1000;
                addr[15:12] = 4'($urandom_range(NS, 15));
            end else begin
                addr[31:16] = 16'h1000;
                addr[15:12] = 4'($urandom_range(0, NS - 1));
            end
            r = $urandom_range(0, 19);
            if (r < 16)       waits = $urandom_range(0, 4);
            else if (r == 16) waits = TO - 2;
            else if (r == 17) waits = TO - 1;
            else if (r == 18) waits = TO;
            else              waits = TO + 3;
            do_access(addr, 1'($urandom), $urandom, 4'($urandom), waits,
                      ($urandom_range(0, 3) == 0), $urandom);
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
        end

        idle_cycles(3);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
